// File: rtl/mux_arb_sched.sv
// Six-requester round-robin burst arbiter driving a registered 6:1 data mux.
// Ownership is held until the burst ends on 'last' or after MAX_BURST beats.
module mux_arb_sched #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        req,
    input  logic [5:0]        last,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] data_3,
    input  logic [DATA_W-1:0] data_4,
    input  logic [DATA_W-1:0] data_5,
    output logic [5:0]        gnt,
    output logic [2:0]        ctrl,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [2:0]        out_src,
    input  logic              out_ready
);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t            r_state;
    logic [2:0]        r_ctrl;
    logic [2:0]        r_ptr;
    logic [3:0]        r_cnt;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [2:0]        r_out_src;

    logic [DATA_W-1:0] w_sel_data;
    logic              w_req_own;
    logic              w_last_own;
    logic              w_found;
    logic [2:0]        w_pick;
    logic              w_accept;
    logic              w_burst_end;

    function automatic logic [2:0] f_wrap(input logic [2:0] p, input int k);
        logic [3:0] s;
        s = {1'b0, p} + 4'(k);
        return (s >= 4'd6) ? 3'(s - 4'd6) : s[2:0];
    endfunction

    // Owner-indexed view of the requester inputs
    always_comb begin
        w_sel_data = data_0;
        w_req_own  = req[0];
        w_last_own = last[0];
        case (r_ctrl)
            3'd1: begin
                w_sel_data = data_1;
                w_req_own  = req[1];
                w_last_own = last[1];
            end
            3'd2: begin
                w_sel_data = data_2;
                w_req_own  = req[2];
                w_last_own = last[2];
            end
            3'd3: begin
                w_sel_data = data_3;
                w_req_own  = req[3];
                w_last_own = last[3];
            end
            3'd4: begin
                w_sel_data = data_4;
                w_req_own  = req[4];
                w_last_own = last[4];
            end
            3'd5: begin
                w_sel_data = data_5;
                w_req_own  = req[5];
                w_last_own = last[5];
            end
            default: begin
                w_sel_data = data_0;
                w_req_own  = req[0];
                w_last_own = last[0];
            end
        endcase
    end

    // Scan upward from the slot after the last burst owner
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        for (int k = 1; k <= 6; k++) begin
            if (!w_found && req[f_wrap(r_ptr, k)]) begin
                w_found = 1'b1;
                w_pick  = f_wrap(r_ptr, k);
            end
        end
    end

    assign w_accept = (r_state == XFER) && w_req_own &&
                      (!r_out_valid || out_ready);

    assign w_burst_end = w_accept &&
                         (w_last_own || (r_cnt + 4'd1 == 4'(MAX_BURST)));

    assign gnt = w_accept ? (6'b000001 << r_ctrl) : 6'b000000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ctrl      <= 3'd0;
            r_ptr       <= 3'd5;
            r_cnt       <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_ctrl  <= w_pick;
                        r_cnt   <= 4'd0;
                        r_state <= XFER;
                    end
                end
                XFER: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                    if (w_burst_end) begin
                        r_ptr   <= r_ctrl;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_src   <= r_ctrl;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign ctrl      = r_ctrl;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_mux_arb_sched.sv
// Bench for mux_arb_sched: directed scenarios plus random traffic,
// scored against a transaction-level arbiter model and a beat queue.
module tb_mux_arb_sched;

    localparam int MB = 4;

    typedef struct packed {
        logic [2:0] src;
        logic [7:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] req;
    logic [5:0] last;
    logic [7:0] d [6];
    logic [5:0] gnt;
    logic [2:0] ctrl;
    logic       out_valid;
    logic [7:0] out_data;
    logic [2:0] out_src;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    beat_t q[$];
    int    glog[$];
    bit    log_en = 0;
    int    wt [6];
    int    wmax = 0;

    bit         m_busy;
    logic [2:0] m_ctrl;
    logic [2:0] m_ptr;
    int         m_cnt;
    bit         m_ov;
    logic [7:0] m_od;
    logic [2:0] m_os;
    logic [5:0] e_gnt;
    logic [2:0] e_ctrl;
    bit         e_ov;
    logic [7:0] e_od;
    logic [2:0] e_os;

    mux_arb_sched #(.DATA_W(8), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .data_0    (d[0]),
        .data_1    (d[1]),
        .data_2    (d[2]),
        .data_3    (d[3]),
        .data_4    (d[4]),
        .data_5    (d[5]),
        .gnt       (gnt),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    // Round-robin choice: first requester after p, wrapping mod 6
    function automatic int pick(int p, logic [5:0] r);
        for (int k = 1; k <= 6; k++)
            if (r[3'((p + k) % 6)]) return (p + k) % 6;
        return -1;
    endfunction

    task automatic m_reset();
        m_busy = 0;
        m_ctrl = 3'd0;
        m_ptr  = 3'd5;
        m_cnt  = 0;
        m_ov   = 0;
        m_od   = 8'h00;
        m_os   = 3'd0;
        e_gnt  = 6'd0;
        e_ctrl = 3'd0;
        e_ov   = 0;
        e_od   = 8'h00;
        e_os   = 3'd0;
        q.delete();
    endtask

    task automatic eval();
        bit    acc;
        int    p;
        beat_t b;
        e_gnt  = 6'd0;
        e_ctrl = m_ctrl;
        e_ov   = m_ov;
        e_od   = m_od;
        e_os   = m_os;
        acc = m_busy && req[m_ctrl] && (!m_ov || out_ready);
        if (acc) begin
            e_gnt[m_ctrl] = 1'b1;
            b.src  = m_ctrl;
            b.data = d[m_ctrl];
            q.push_back(b);
        end
        if (!m_busy) begin
            p = pick(int'(m_ptr), req);
            if (p >= 0) begin
                m_ctrl = 3'(p);
                m_cnt  = 0;
                m_busy = 1;
            end
        end else if (acc) begin
            m_cnt++;
            if (last[m_ctrl] || m_cnt == MB) begin
                m_ptr  = m_ctrl;
                m_busy = 0;
            end
        end
        if (acc) begin
            m_ov = 1;
            m_od = d[e_ctrl];
            m_os = e_ctrl;
        end else if (out_ready) begin
            m_ov = 0;
        end
    endtask

    task automatic step(input logic [5:0] r, input logic [5:0] l,
                        input logic rdy, input logic [7:0] base,
                        input bit rnd);
        @(posedge clk);
        #1;
        req       = r;
        last      = l;
        out_ready = rdy;
        for (int i = 0; i < 6; i++)
            d[i] = rnd ? 8'($urandom) : base + 8'(i);
        eval();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req   = 6'd0;
        last  = 6'd0;
        m_reset();
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_ctrl", ctrl, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_src", out_src, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) wt[i] = 0;
        eval();
    endtask

    // Monitor: cycle-level compare plus in-order beat consumption
    always @(negedge clk) begin
        if (rst_n) begin
            beat_t b;
            chk("gnt", gnt, e_gnt);
            chk("ctrl", ctrl, e_ctrl);
            chk("out_valid", out_valid, e_ov);
            if (e_ov) begin
                chk("out_data", out_data, e_od);
                chk("out_src", out_src, e_os);
            end
            chk("invariant", (ctrl > 5) || (out_src > 5) ||
                ((gnt & (gnt - 6'd1)) != 0), 0);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("pop_empty", 1, 0);
                end else begin
                    b = q.pop_front();
                    chk("sb_data", out_data, b.data);
                    chk("sb_src", out_src, b.src);
                end
            end
            for (int i = 0; i < 6; i++) begin
                if (!req[i] || gnt[i]) wt[i] = 0;
                else if (gnt != 0) wt[i]++;
                if (wt[i] > wmax) wmax = wt[i];
                if (log_en && gnt[i]) glog.push_back(i);
            end
        end
    end

    initial begin
        logic [7:0] held;
        rst_n     = 1'b0;
        req       = 6'd0;
        last      = 6'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) d[i] = 8'h00;
        m_reset();

        do_reset();
        repeat (3) step(6'b000001, 6'b000001, 1'b1, 8'hA5, 0);
        #2;
        chk("r029_valid", out_valid, 1);
        chk("r029_data", out_data, 8'hA5);
        chk("r029_src", out_src, 0);

        do_reset();
        glog.delete();
        log_en = 1;
        repeat (14) step(6'b111111, 6'b111111, 1'b1, 8'h10, 0);
        #6;
        log_en = 0;
        chk("r030_count", glog.size(), 7);
        for (int i = 0; i < 7 && i < glog.size(); i++)
            chk("r030_order", glog[i], i % 6);

        do_reset();
        glog.delete();
        log_en = 1;
        repeat (8) step(6'b001100, 6'b000000, 1'b1, 8'h20, 1);
        #6;
        log_en = 0;
        chk("r031_count", glog.size(), 6);
        for (int i = 0; i < 5 && i < glog.size(); i++)
            chk("r031_order", glog[i], (i < 4) ? 2 : 3);

        do_reset();
        step(6'b000010, 6'b000000, 1'b1, 8'h40, 0);
        step(6'b000010, 6'b000000, 1'b1, 8'h40, 0);
        held = d[1];
        for (int i = 0; i < 5; i++) begin
            step(6'b000010, 6'b000000, 1'b0, 8'h60 + 8'(i * 8), 0);
            #2;
            chk("r032_stall_gnt", gnt, 0);
            chk("r032_stable", out_data, held);
        end
        step(6'b000010, 6'b000000, 1'b1, 8'h90, 0);
        #2;
        chk("r032_resume", gnt, 6'b000010);

        do_reset();
        repeat (3) step(6'b001000, 6'b000000, 1'b1, 8'hB0, 0);
        do_reset();
        step(6'b111111, 6'b000000, 1'b1, 8'hC0, 0);
        #2;
        chk("r033_nognt", gnt, 0);
        step(6'b111111, 6'b000000, 1'b1, 8'hC0, 0);
        #2;
        chk("r033_restart", gnt, 6'b000001);
        chk("r033_ctrl", ctrl, 0);

        do_reset();
        wmax = 0;
        for (int n = 0; n < 10000; n++)
            step(6'($urandom), 6'($urandom & $urandom),
                 1'($urandom_range(0, 3) != 0), 8'h00, 1);
        repeat (4) step(6'd0, 6'd0, 1'b1, 8'h00, 1);
        #6;
        chk("drain", q.size(), 0);
        chk("starve", wmax > 5 * (MB + 1), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_arb_sched.md
MUX_ARB_SCHED -- requirements
Module: mux_arb_sched

Interface
REQ-001 Parameter: DATA_W, default 8, width of every data input and of out_data.
REQ-002 Parameter: MAX_BURST, default 4, maximum beats per grant before forced re-arbitration (legal range 1..15).
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: req  input  6  per-requester valid; bit i qualifies data_i.
REQ-006 Port: last  input  6  bit i marks the current beat of requester i as the final beat of its burst.
REQ-007 Port: data_0 .. data_5  input  DATA_W each  requester payloads, one per requester index.
REQ-008 Port: gnt  output  6  one-hot accept pulse; bit i high means the data_i beat is consumed this cycle.
REQ-009 Port: ctrl  output  3  registered select for the shared 6:1 mux; encodes the owner index 0..5.
REQ-010 Port: out_valid  output  1  out_data holds an unconsumed beat.
REQ-011 Port: out_data  output  DATA_W  registered selected payload.
REQ-012 Port: out_src  output  3  requester index that produced out_data.
REQ-013 Port: out_ready  input  1  downstream accepts out_data when high with out_valid.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and XFER.
REQ-015 In IDLE with any req bit high, the block SHALL select the first requesting index scanning upward, with wrap, from (ptr+1) mod 6, load it into ctrl/owner, clear the beat count, and enter XFER next cycle.
REQ-016 In IDLE, gnt SHALL be all zeros; ctrl SHALL hold its previous value.
REQ-017 In XFER, a beat is accepted when req[owner]=1 and (out_valid=0 or out_ready=1); only then SHALL gnt[owner]=1, all other gnt bits being 0.
REQ-018 On accept, out_data SHALL load data_owner, out_src SHALL load owner, and out_valid SHALL be 1 on the next cycle (latency 1 from gnt to out_data).
REQ-019 When out_ready=1 with out_valid=1 and no accept occurs in the same cycle, out_valid SHALL clear next cycle.
REQ-020 While out_valid=1 and out_ready=0, out_data and out_src SHALL remain stable and gnt SHALL be 0.
REQ-021 The beat count SHALL increment on each accept; an accept with last[owner]=1 or count reaching MAX_BURST SHALL set ptr=owner and return the FSM to IDLE.
REQ-022 If req[owner] drops mid-burst, ownership SHALL be retained (no re-arbitration) until the burst terminates per REQ-021.
REQ-023 Requests arriving on other indices during XFER SHALL NOT affect ctrl or gnt.
REQ-024 ctrl and out_src SHALL never take values 6 or 7.
REQ-025 Minimum gap between the final beat of one burst and the first beat of the next SHALL be exactly one IDLE cycle.

Reset
REQ-026 While rst_n=0, regardless of clk: state=IDLE, ctrl=0, gnt=0, out_valid=0, out_data=0, out_src=0, beat count=0, ptr=5 (index 0 has first priority).
REQ-027 Reset asserted mid-burst SHALL discard the burst and any pending out_data, with no gnt pulse during or immediately after reset release.
REQ-028 The first arbitration SHALL occur on the first rising clk edge after rst_n deasserts.

Verification
REQ-029 After reset, req=6'b000001, last=6'b000001, data_0=8'hA5, out_ready=1 -> ctrl=0 one cycle later; gnt=6'b000001 in the XFER cycle; out_valid=1, out_data=8'hA5, out_src=0 on the next cycle.
REQ-030 req=6'b111111, last=6'b111111, out_ready=1 held -> successive gnt order 0,1,2,3,4,5,0 with one idle cycle between grants.
REQ-031 MAX_BURST=4, req[2]=req[3]=1, last=0 -> exactly four gnt[2] pulses, then IDLE, then ownership passes to 3.
REQ-032 During XFER with out_valid=1, out_ready=0 for 5 cycles -> gnt=0 and out_data stable for all 5 cycles; out_ready=1 -> accepts resume in the same cycle.
REQ-033 rst_n pulsed low mid-burst (after beat 2 of 4) -> all outputs at reset values immediately; after release, arbitration restarts at index 0.
REQ-034 Randomized req/last/out_ready for 10k cycles -> ctrl never 6 or 7, gnt always zero or one-hot, and no requester is starved longer than 5 x (MAX_BURST+1) accepts.
